// File: rtl/spi_pkg.sv
// Shared constants for the parametrised SPI slave: mode encodings and word-width limits.
package spi_pkg;

    // Mode encodings as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_WIDTH_MIN = 4;
    localparam int unsigned SPI_WIDTH_MAX = 32;

    function automatic bit spi_width_ok(input int unsigned w);
        return (w >= SPI_WIDTH_MIN) && (w <= SPI_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, with a selectable reset level.
module spi_sync #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: configurable width, CPOL/CPHA and bit order, multi-word frames,
// one-entry transmit holding register with valid/ready toward the host.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS,
    input  logic             SCK,
    input  logic             MOSI,
    output logic             MISO,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun
);

    localparam int unsigned CNT_W       = $clog2(WIDTH + 1);
    localparam logic [1:0]  MODE        = {CPOL, CPHA};
    localparam bit          SAMPLE_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

    if (!spi_width_ok(WIDTH)) begin : g_width_check
        $error("spi_slave_param: WIDTH must be within 4..32");
    end

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t           state;
    logic             ss_s, sck_s, mosi_s;
    logic             ss_d, sck_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rx_sr, tx_sr, hold_data;
    logic             word_done;

    logic             sck_rise, sck_fall;
    logic             frame_start, frame_end, sample_edge, shift_edge, last_bit, load;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endfunction

    // SS resets low so a frame already in progress at reset release is never joined
    spi_sync #(.W(1), .RST_VAL(1'b0)) u_sync_ss   (.clk(clk), .rst(rst), .d(SS),   .q(ss_s));
    spi_sync #(.W(1), .RST_VAL(CPOL)) u_sync_sck  (.clk(clk), .rst(rst), .d(SCK),  .q(sck_s));
    spi_sync #(.W(1), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(MOSI), .q(mosi_s));

    always_comb begin
        sck_rise    = sck_s & ~sck_d;
        sck_fall    = ~sck_s & sck_d;
        frame_start = (state == S_IDLE) && ss_d && !ss_s;
        frame_end   = (state == S_ACTIVE) && ss_s;
        sample_edge = (state == S_ACTIVE) && !ss_s && (SAMPLE_RISE ? sck_rise : sck_fall);
        // With CPHA=0 the shift edge right after a word boundary would skip the freshly loaded first bit
        shift_edge  = (state == S_ACTIVE) && !ss_s && (SAMPLE_RISE ? sck_fall : sck_rise)
                      && ((CPHA == 1'b1) || (cnt != '0));
        last_bit    = sample_edge && (cnt == CNT_W'(WIDTH - 1));
        load        = frame_start || last_bit;
        load_word   = tx_ready ? '0 : hold_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ss_d        <= 1'b0;
            sck_d       <= CPOL;
            cnt         <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            hold_data   <= '0;
            word_done   <= 1'b0;
            MISO        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            ss_d        <= ss_s;
            sck_d       <= sck_s;
            word_done   <= 1'b0;
            rx_valid    <= word_done;
            tx_underrun <= 1'b0;
            if (word_done) begin
                rx_data <= rx_sr;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state   <= S_ACTIVE;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                        cnt     <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (frame_end) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        MISO    <= 1'b0;
                        cnt     <= '0;
                    end else if (sample_edge) begin
                        rx_sr     <= MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_s} : {mosi_s, rx_sr[WIDTH-1:1]};
                        cnt       <= last_bit ? '0 : cnt + CNT_W'(1);
                        word_done <= last_bit;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (shift_edge) begin
                MISO  <= first_bit(tx_sr);
                tx_sr <= shift_word(tx_sr);
            end

            // CPHA=0 presents the first bit at load time; CPHA=1 waits for the leading edge
            if (load) begin
                if (CPHA == 1'b1) begin
                    tx_sr <= load_word;
                end else begin
                    MISO  <= first_bit(load_word);
                    tx_sr <= shift_word(load_word);
                end
                if (tx_ready) begin
                    tx_underrun <= 1'b1;
                end else begin
                    tx_ready <= 1'b1;
                end
            end

            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                tx_ready  <= 1'b0;
            end
        end
    end

endmodule
